key_bcd_entry: RTL and testbench

KEY_BCD_ENTRY -- requirements
Module: key_bcd_entry

---
 rtl/key_bcd_entry.sv | 213 +++++++++++++++++++++
 tb/tb_key_bcd_entry.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/key_bcd_entry.sv
// Scanned 4x4 keypad front end: row scan, press/release debounce, and a 4-digit BCD entry buffer.
// Keys 0-9 shift digits in, A backspaces, B clears, C commits the entry to value, D-F only update keycode.
module key_bcd_entry #(
    parameter int unsigned SCAN_DIV = 16384,
    parameter int unsigned DEB_CNT  = 8
) (
    input  logic        clk,
    input  logic        clr,
    input  logic [3:0]  col,
    output logic [3:0]  row,
    output logic [15:0] entry,
    output logic [2:0]  ndig,
    output logic [15:0] value,
    output logic        valid,
    output logic [3:0]  keycode
);

    localparam int unsigned DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned CNT_W = $clog2(DEB_CNT + 1);

    typedef enum logic [1:0] {
        S_SCAN,
        S_PDEB,
        S_HELD,
        S_RDEB
    } state_t;

    logic [3:0]       r_col_s1;
    logic [3:0]       r_col_s2;
    logic [DIV_W-1:0] r_div;
    logic             w_tick;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [1:0]       r_ridx;
    logic [1:0]       w_ridx_nxt;
    logic [3:0]       r_cand;
    logic [3:0]       w_cand_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [CNT_W-1:0] w_cnt_inc;
    logic             w_cnt_done;

    logic [3:0]       r_row;
    logic [15:0]      r_entry;
    logic [2:0]       r_ndig;
    logic [15:0]      r_value;
    logic             r_valid;
    logic [3:0]       r_keycode;
    logic [15:0]      w_entry_nxt;
    logic [2:0]       w_ndig_nxt;
    logic [15:0]      w_value_nxt;
    logic             w_valid_nxt;
    logic [3:0]       w_keycode_nxt;

    logic             w_any;
    logic [1:0]       w_cidx;
    logic [3:0]       w_code;
    logic             w_accept;

    // Column synchronizer and free-running scan divider
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_col_s1 <= 4'hF;
            r_col_s2 <= 4'hF;
            r_div    <= '0;
        end else begin
            r_col_s1 <= col;
            r_col_s2 <= r_col_s1;
            r_div    <= w_tick ? '0 : r_div + DIV_W'(1);
        end
    end

    assign w_tick = (r_div == DIV_W'(SCAN_DIV - 1));

    // Lowest-index low column wins when several keys share the driven row
    always_comb begin
        w_cidx = 2'd0;
        if (!r_col_s2[0])      w_cidx = 2'd0;
        else if (!r_col_s2[1]) w_cidx = 2'd1;
        else if (!r_col_s2[2]) w_cidx = 2'd2;
        else if (!r_col_s2[3]) w_cidx = 2'd3;
    end

    assign w_any      = ~&r_col_s2;
    assign w_code     = {r_ridx, w_cidx};
    assign w_cnt_inc  = r_cnt + CNT_W'(1);
    assign w_cnt_done = (r_cnt >= CNT_W'(DEB_CNT - 1));

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_state   <= S_SCAN;
            r_ridx    <= 2'd0;
            r_cand    <= 4'h0;
            r_cnt     <= '0;
            r_row     <= 4'b1110;
            r_entry   <= 16'h0000;
            r_ndig    <= 3'd0;
            r_value   <= 16'h0000;
            r_valid   <= 1'b0;
            r_keycode <= 4'h0;
        end else begin
            r_state   <= w_state_nxt;
            r_ridx    <= w_ridx_nxt;
            r_cand    <= w_cand_nxt;
            r_cnt     <= w_cnt_nxt;
            r_row     <= ~(4'b0001 << w_ridx_nxt);
            r_entry   <= w_entry_nxt;
            r_ndig    <= w_ndig_nxt;
            r_value   <= w_value_nxt;
            r_valid   <= w_valid_nxt;
            r_keycode <= w_keycode_nxt;
        end
    end

    // Scan/debounce FSM; every transition is gated by the scan tick
    always_comb begin
        w_state_nxt = r_state;
        w_ridx_nxt  = r_ridx;
        w_cand_nxt  = r_cand;
        w_cnt_nxt   = r_cnt;
        w_accept    = 1'b0;
        if (w_tick) begin
            case (r_state)
                S_SCAN: begin
                    if (w_any) begin
                        w_cand_nxt = w_code;
                        w_cnt_nxt  = CNT_W'(1);
                        if (DEB_CNT <= 1) begin
                            w_accept    = 1'b1;
                            w_state_nxt = S_HELD;
                        end else begin
                            w_state_nxt = S_PDEB;
                        end
                    end else begin
                        w_ridx_nxt = r_ridx + 2'd1;
                    end
                end
                S_PDEB: begin
                    if (w_any && (w_code == r_cand)) begin
                        w_cnt_nxt = w_cnt_inc;
                        if (w_cnt_done) begin
                            w_accept    = 1'b1;
                            w_state_nxt = S_HELD;
                        end
                    end else begin
                        w_state_nxt = S_SCAN;
                    end
                end
                S_HELD: begin
                    if (!w_any) begin
                        w_cnt_nxt   = CNT_W'(1);
                        w_state_nxt = (DEB_CNT <= 1) ? S_SCAN : S_RDEB;
                    end
                end
                S_RDEB: begin
                    if (w_any) begin
                        w_state_nxt = S_HELD;
                    end else begin
                        w_cnt_nxt = w_cnt_inc;
                        if (w_cnt_done) w_state_nxt = S_SCAN;
                    end
                end
                default: w_state_nxt = S_SCAN;
            endcase
        end

        w_entry_nxt   = r_entry;
        w_ndig_nxt    = r_ndig;
        w_value_nxt   = r_value;
        w_valid_nxt   = 1'b0;
        w_keycode_nxt = r_keycode;
        if (w_accept) begin
            w_keycode_nxt = w_code;
            if (w_code <= 4'd9) begin
                if (r_ndig < 3'd4) begin
                    w_entry_nxt = {r_entry[11:0], w_code};
                    w_ndig_nxt  = r_ndig + 3'd1;
                end
            end else begin
                case (w_code)
                    4'hA: begin
                        if (r_ndig != 3'd0) begin
                            w_entry_nxt = {4'h0, r_entry[15:4]};
                            w_ndig_nxt  = r_ndig - 3'd1;
                        end
                    end
                    4'hB: begin
                        w_entry_nxt = 16'h0000;
                        w_ndig_nxt  = 3'd0;
                    end
                    4'hC: begin
                        if (r_ndig != 3'd0) begin
                            w_value_nxt = r_entry;
                            w_valid_nxt = 1'b1;
                            w_entry_nxt = 16'h0000;
                            w_ndig_nxt  = 3'd0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign row     = r_row;
    assign entry   = r_entry;
    assign ndig    = r_ndig;
    assign value   = r_value;
    assign valid   = r_valid;
    assign keycode = r_keycode;

endmodule

// File: tb/tb_key_bcd_entry.sv
// Directed bench for key_bcd_entry: a behavioural keypad matrix drives col from the scanned row.
module tb_key_bcd_entry;

    logic        clk;
    logic        clr;
    logic [3:0]  col;
    logic [3:0]  row;
    logic [15:0] entry;
    logic [2:0]  ndig;
    logic [15:0] value;
    logic        valid;
    logic [3:0]  keycode;

    logic [15:0] keys;
    int          checks;
    int          failures;
    int          n_valid;

    key_bcd_entry #(.SCAN_DIV(4), .DEB_CNT(3)) dut (
        .clk     (clk),
        .clr     (clr),
        .col     (col),
        .row     (row),
        .entry   (entry),
        .ndig    (ndig),
        .value   (value),
        .valid   (valid),
        .keycode (keycode)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Key k sits at row k/4, column k%4; a pressed key pulls its column low while its row is driven
    always_comb begin
        col = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys[4*r+c] && !row[r]) col[c] = 1'b0;
    end

    always @(posedge clk) if (valid) n_valid++;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input int k);
        keys[k] = 1'b1;
        cycles(80);
        keys = 16'h0;
        cycles(40);
    endtask

    int v0;
    int run;
    logic found;

    initial begin
        checks = 0; failures = 0; n_valid = 0;
        keys = 16'h0;
        clr = 1'b0;
        cycles(3);
        check("rst_row",   16'(row), 16'h000E);
        check("rst_entry", entry, 16'h0000);
        check("rst_ndig",  16'(ndig), 16'h0000);
        check("rst_value", value, 16'h0000);
        check("rst_valid", 16'(valid), 16'h0000);
        check("rst_key",   16'(keycode), 16'h0000);
        clr = 1'b1;
        cycles(4);

        press(1); check("e_1",    entry, 16'h0001);
        press(2); check("e_12",   entry, 16'h0012);
        press(3); check("e_123",  entry, 16'h0123);
        press(4); check("e_1234", entry, 16'h1234);
        check("nd_4", 16'(ndig), 16'h0004);
        v0 = n_valid;
        press(12);
        check("ent_pulse", 16'(n_valid - v0), 16'h0001);
        check("ent_value", value, 16'h1234);
        check("ent_entry", entry, 16'h0000);
        check("ent_ndig",  16'(ndig), 16'h0000);
        check("ent_key",   16'(keycode), 16'h000C);

        press(9); press(8); press(7); press(6);
        check("e_9876", entry, 16'h9876);
        press(5);
        check("full_entry", entry, 16'h9876);
        check("full_ndig",  16'(ndig), 16'h0004);
        check("full_key",   16'(keycode), 16'h0005);
        press(10);
        check("bs_entry", entry, 16'h0987);
        check("bs_ndig",  16'(ndig), 16'h0003);

        press(11);
        check("clr_entry", entry, 16'h0000);
        check("clr_ndig",  16'(ndig), 16'h0000);
        v0 = n_valid;
        press(12);
        check("ent0_pulse", 16'(n_valid - v0), 16'h0000);
        check("ent0_value", value, 16'h1234);
        check("ent0_key",   16'(keycode), 16'h000C);
        press(7); press(7);
        check("e_77", entry, 16'h0077);
        press(11);
        check("clr77_entry", entry, 16'h0000);
        check("clr77_value", value, 16'h1234);
        press(13);
        check("d_key",   16'(keycode), 16'h000D);
        check("d_entry", entry, 16'h0000);

        // Bounce digit 3 for two ticks, then hold it for about 100 ticks
        repeat (2) begin
            keys[3] = 1'b1; cycles(4);
            keys[3] = 1'b0; cycles(4);
        end
        keys[3] = 1'b1;
        cycles(80);
        check("bounce_entry", entry, 16'h0003);
        cycles(320);
        check("hold_entry", entry, 16'h0003);
        check("hold_ndig",  16'(ndig), 16'h0001);
        keys = 16'h0;
        cycles(40);

        // Keys 4 and 6 share row 1; column 0 wins
        keys[4] = 1'b1; keys[6] = 1'b1;
        cycles(80);
        keys = 16'h0;
        cycles(40);
        check("multi_key",   16'(keycode), 16'h0004);
        check("multi_entry", entry, 16'h0034);

        // Wait until row 0 is frozen (press debounce in progress), then reset
        keys[1] = 1'b1;
        found = 1'b0; run = 0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clk);
            run = (row == 4'b1110) ? run + 1 : 0;
            if (run == 6) found = 1'b1;
        end
        check("pdeb_reached", 16'(found), 16'h0001);
        check("pdeb_entry",   entry, 16'h0034);
        clr = 1'b0;
        #1;
        check("abort_row",   16'(row), 16'h000E);
        check("abort_entry", entry, 16'h0000);
        check("abort_value", value, 16'h0000);
        check("abort_key",   16'(keycode), 16'h0000);
        check("abort_ndig",  16'(ndig), 16'h0000);
        keys = 16'h0;
        cycles(3);
        clr = 1'b1;
        cycles(60);
        check("post_entry", entry, 16'h0000);
        check("post_key",   16'(keycode), 16'h0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
